// File: rtl/soc_system_led_driver_if.sv
// Avalon-MM slave bus for the LED driver register block.
//   address    : word address (0 CTRL, 1 BRIGHT, 2 BLINK_DIV, 3 STATUS)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : combinational read data, zero wait states
interface soc_system_led_driver_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_led_driver.sv
// LED driver: registers the upstream LED pattern and gates it with a
// brightness PWM and an optional blink, both configured over Avalon-MM.
//   clk      : system clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (register map CTRL/BRIGHT/BLINK_DIV/STATUS)
//   led_in   : LED pattern from the upstream PIO, synchronous to clk
//   led_out  : registered drive to the board LEDs
module soc_system_led_driver (
   input  logic                          clk,
   input  logic                          reset_n,
   soc_system_led_driver_if.slave        bus,
   input  logic [9:0]                    led_in,
   output logic [9:0]                    led_out
);

   localparam logic [1:0]  CTRL_RST   = 2'b01;
   localparam logic [7:0]  BRIGHT_RST = 8'hFF;
   localparam logic [23:0] DIV_RST    = 24'hBEBC1F;  // 2 Hz blink at 50 MHz

   logic [1:0]  ctrl_q, ctrl_d;
   logic [7:0]  bright_q, bright_d;
   logic [23:0] div_q, div_d;
   logic [7:0]  pwm_q, pwm_d;
   logic [23:0] bcnt_q, bcnt_d;
   logic        phase_q, phase_d;
   logic [9:0]  led_q;
   logic [9:0]  led_out_q, led_out_d;

   logic wr, en, blink_run, pwm_on;

   // Upper write-data bits carry nothing.
   logic unused_wd;
   assign unused_wd = &{1'b0, bus.writedata[31:24]};

   assign wr        = bus.chipselect & ~bus.write_n;
   assign en        = ctrl_q[0];
   assign blink_run = ctrl_q[0] & ctrl_q[1];
   assign pwm_on    = (bright_q == 8'hFF) | (pwm_q < bright_q);

   always_comb begin
      ctrl_d   = ctrl_q;
      bright_d = bright_q;
      div_d    = div_q;
      if (wr) begin
         case (bus.address)
            2'd0:    ctrl_d   = bus.writedata[1:0];
            2'd1:    bright_d = bus.writedata[7:0];
            2'd2:    div_d    = bus.writedata[23:0];
            default: ;  // STATUS is read-only
         endcase
      end

      pwm_d = en ? pwm_q + 8'd1 : 8'd0;

      // Compare against the divider in force this cycle; a divider write on
      // the same edge still lets the wrap toggle the phase, then restarts
      // the count so the new divider governs from zero.
      bcnt_d  = 24'd0;
      phase_d = 1'b1;
      if (blink_run) begin
         phase_d = phase_q;
         if (bcnt_q == div_q) begin
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + 24'd1;
         end
         if (wr && bus.address == 2'd2) bcnt_d = 24'd0;
      end

      led_out_d = led_q & {10{en & pwm_on & phase_q}};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q    <= CTRL_RST;
         bright_q  <= BRIGHT_RST;
         div_q     <= DIV_RST;
         pwm_q     <= 8'd0;
         bcnt_q    <= 24'd0;
         phase_q   <= 1'b1;
         led_q     <= 10'd0;
         led_out_q <= 10'd0;
      end else begin
         ctrl_q    <= ctrl_d;
         bright_q  <= bright_d;
         div_q     <= div_d;
         pwm_q     <= pwm_d;
         bcnt_q    <= bcnt_d;
         phase_q   <= phase_d;
         led_q     <= led_in;
         led_out_q <= led_out_d;
      end
   end

   always_comb begin
      bus.readdata = 32'd0;
      if (bus.chipselect) begin
         case (bus.address)
            2'd0:    bus.readdata = {30'd0, ctrl_q};
            2'd1:    bus.readdata = {24'd0, bright_q};
            2'd2:    bus.readdata = {8'd0, div_q};
            default: bus.readdata = {23'd0, phase_q, pwm_q};
         endcase
      end
   end

   assign led_out = led_out_q;

endmodule

// File: doc/soc_system_led_driver.md
SOC_SYSTEM_LED_DRIVER -- requirements
Module: soc_system_led_driver

Interface
REQ-001 SHALL have no parameters; all widths are fixed: 10 LEDs, 8-bit PWM, 24-bit blink divider.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 address  input  2  Avalon-MM slave word address.
REQ-005 chipselect  input  1  slave select.
REQ-006 write_n  input  1  active-low write strobe.
REQ-007 writedata  input  32  write data.
REQ-008 readdata  output  32  read data; combinational, zero wait states.
REQ-009 led_in  input  10  LED pattern from the upstream LED PIO out_port; synchronous to clk.
REQ-010 led_out  output  10  registered drive to the board LEDs.

Function
REQ-011 Register map SHALL be: 0 CTRL (bit0 enable, bit1 blink_en); 1 BRIGHT[7:0] duty; 2 BLINK_DIV[23:0]; 3 STATUS, read-only ({blink_phase at bit8, pwm_cnt[7:0]}).
REQ-012 A write SHALL occur when chipselect=1 and write_n=0; the register updates on that clock edge; writes to address 3 SHALL be ignored; unused writedata bits SHALL be ignored.
REQ-013 readdata SHALL reflect the addressed register, zero-extended, in the same cycle; it SHALL be 0 when chipselect=0.
REQ-014 led_in SHALL be registered once into led_q; led_out SHALL be registered from led_q.
REQ-015 The PWM counter pwm_cnt (8 bit) SHALL increment by 1 every cycle while enable=1, wrapping 255->0, giving a 256-cycle period; while enable=0 it SHALL be held at 0.
REQ-016 pwm_on SHALL be 1 when BRIGHT=255, otherwise (pwm_cnt < BRIGHT); BRIGHT=0 SHALL give pwm_on=0 always.
REQ-017 Blink counter (24 bit) SHALL increment each cycle while enable=1 and blink_en=1; when it equals BLINK_DIV it SHALL reset to 0 and toggle blink_phase on the same edge.
REQ-018 BLINK_DIV=0 SHALL toggle blink_phase every cycle.
REQ-019 While blink_en=0 or enable=0, the blink counter SHALL be held at 0 and blink_phase forced to 1.
REQ-020 A write to BLINK_DIV SHALL clear the blink counter on the same edge; blink_phase SHALL be unchanged.
REQ-021 A write to CTRL that sets blink_en from 0 to 1 SHALL start counting from 0 with blink_phase=1.
REQ-022 led_out[i] next SHALL be led_q[i] & enable & pwm_on & blink_phase, for each i in 0..9.
REQ-023 Latency SHALL be 2 cycles from led_in to led_out with enable=1, BRIGHT=255 and blink_en=0.
REQ-024 A register write and a counter wrap on the same edge SHALL both take effect; the written value governs from the next cycle.

Reset
REQ-025 On reset_n=0 (asynchronous): CTRL=0x1, BRIGHT=0xFF, BLINK_DIV=0xBEBC1F (2 Hz blink at 50 MHz), pwm_cnt=0, blink counter=0, blink_phase=1, led_q=0, led_out=0.
REQ-026 Reset asserted mid-PWM or mid-blink SHALL immediately clear led_out to 0; after release, operation SHALL resume from the reset values with no stale state.

Verification
REQ-027 Reset then led_in=0x2A5 -> led_out=0x2A5 two cycles later; readdata at address 0 = 0x1; address 1 = 0xFF; address 2 = 0xBEBC1F.
REQ-028 Write BRIGHT=64, led_in=0x3FF -> over any 256-cycle window led_out=0x3FF for exactly 64 cycles and 0 for 192; BRIGHT=0 -> led_out stays 0.
REQ-029 Write BLINK_DIV=3, CTRL=0x3, BRIGHT=255, led_in=0x001 -> led_out[0] alternates 4 cycles on and 4 cycles off; STATUS bit8 tracks blink_phase.
REQ-030 Write CTRL=0x0 -> led_out=0 from the next cycle; STATUS=0x100. Then write CTRL=0x1 -> pwm_cnt restarts from 0.
REQ-031 Assert reset_n mid-blink while led_out=0x001 -> led_out=0 asynchronously; after release all registers read back their reset values.
REQ-032 Write BLINK_DIV at the cycle the counter equals the old BLINK_DIV -> phase toggles once and the counter restarts from 0 against the new divider; write to address 3 -> no register changes.
